// File: rtl/soc_perf_port_arbiter.sv
// soc_perf_port_arbiter: round-robin arbiter sharing the performance analyzer register port.
// Optional address range rejection compiled in with SOC_PERF_ARB_ADDR_CHECK_EN.
module soc_perf_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int REG_COUNT    = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         read_address,
    output logic [DATA_W-1:0]         write_data,
    output logic                      write,
    output logic                      read,
    input  logic [DATA_W-1:0]         read_data
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = IDX_W + 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [IDX_W-1:0]  ptr, ptr_next, gnt_idx, gnt_reg, rsp_idx;
    logic [CW-1:0]     cand;
    logic              gnt_found;
    logic              grant;
    logic              cmd_write;
    logic              addr_err;
    logic [LAT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] gnt_addr;

    // first valid requester at or after ptr, wrapping cyclically
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ))
                cand = cand - CW'(NUM_REQ);
            if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        if (gnt_idx == IDX_W'(NUM_REQ - 1))
            ptr_next = '0;
        else
            ptr_next = gnt_idx + IDX_W'(1);
    end

    assign gnt_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];

`ifdef SOC_PERF_ARB_ADDR_CHECK_EN
    assign addr_err = (32'(gnt_addr) >= 32'(REG_COUNT));
`else
    assign addr_err = 1'b0;
`endif

    assign busy    = (state != IDLE);
    assign rsp_idx = grant ? gnt_idx : gnt_reg;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        read       = 1'b0;
        write      = 1'b0;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found && !reset) begin
                    grant              = 1'b1;
                    req_ready[gnt_idx] = 1'b1;
                    state_next         = addr_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                write      = cmd_write;
                read       = !cmd_write;
                state_next = cmd_write ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr          <= '0;
            gnt_reg      <= '0;
            cmd_write    <= 1'b0;
            wait_cnt     <= '0;
            read_address <= '0;
            write_data   <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (grant) begin
                ptr       <= ptr_next;
                gnt_reg   <= gnt_idx;
                cmd_write <= req_write[gnt_idx];
                // rejected commands leave the analyzer port untouched
                if (!addr_err) begin
                    read_address <= gnt_addr;
                    write_data   <= req_wdata[gnt_idx*DATA_W +: DATA_W];
                end
            end
            if (state == ISSUE)
                wait_cnt <= LAT_W'(READ_LATENCY - 1);
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - LAT_W'(1);
            if (state == WAIT && wait_cnt == '0)
                rsp_rdata <= read_data;
            else if (state_next == RESP && state != WAIT && state != RESP)
                rsp_rdata <= '0;
            if (state_next == RESP && state != RESP) begin
                rsp_valid[rsp_idx] <= 1'b1;
                rsp_err            <= grant && addr_err;
            end
        end
    end
endmodule
